// File: rtl/cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe
//
// Pipelined adder/subtractor. The operand word is split into STAGES slices of
// WIDTH/STAGES bits. Each slice is a two-level carry-lookahead adder: 4-bit
// (GROUP) lookahead groups whose group generate/propagate feed a slice-level
// lookahead. There is no ripple between groups. Stage k adds slice k using the
// carry registered by stage k-1. The last stage also produces the flags.
//
// Optional feature: define CLA_ADDSUB_SAT_EN to add the 'sat' input. When
// sat=1 and the signed result overflows, sum clamps to the largest positive or
// most negative value.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Producers hold data stable while valid && !ready. in_ready combinationally
// depends on out_ready through the stage-advance chain.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b, sub, cin[, sat])
//   a, b                operands
//   sub                 1 = a + ~b + cin, 0 = a + b + cin
//   cin                 carry in (for subtract, 1 = no borrow)
//   sat                 saturate on signed overflow (CLA_ADDSUB_SAT_EN only)
//   out_valid/out_ready result handshake (sum, cout, ovf, zero)
//   sum                 result modulo 2^WIDTH (or clamped)
//   cout                carry out of the MSB
//   ovf                 two's-complement overflow
//   zero                sum == 0
// -----------------------------------------------------------------------------
module cla_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
`ifdef CLA_ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int NGRP  = SLICE / GROUP;

    // Returns {carry into slice MSB, carry out of slice, slice sum}.
    function automatic logic [SLICE+1:0] slice_add(input logic [SLICE-1:0] x,
                                                   input logic [SLICE-1:0] y,
                                                   input logic ci);
        logic [SLICE-1:0] g, p, c;
        logic [NGRP-1:0]  gg, gp;
        logic [NGRP:0]    gc;
        logic             term, t2;
        g = x & y;
        p = x | y;
        // Group generate/propagate.
        for (int j = 0; j < NGRP; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                term = g[j*GROUP+i];
                for (int k = i + 1; k < GROUP; k++) term = term & p[j*GROUP+k];
                gg[j] = gg[j] | term;
                gp[j] = gp[j] & p[j*GROUP+i];
            end
        end
        // Slice-level lookahead: every group carry is a flat sum of products.
        for (int j = 0; j <= NGRP; j++) begin
            term = ci;
            for (int i = 0; i < j; i++) term = term & gp[i];
            gc[j] = term;
            for (int i = 0; i < j; i++) begin
                term = gg[i];
                for (int k = i + 1; k < j; k++) term = term & gp[k];
                gc[j] = gc[j] | term;
            end
        end
        // Bit carries inside each group from that group's incoming carry.
        for (int j = 0; j < NGRP; j++) begin
            for (int i = 0; i < GROUP; i++) begin
                term = gc[j];
                for (int k = 0; k < i; k++) term = term & p[j*GROUP+k];
                for (int k = 0; k < i; k++) begin
                    t2 = g[j*GROUP+k];
                    for (int m = k + 1; m < i; m++) t2 = t2 & p[j*GROUP+m];
                    term = term | t2;
                end
                c[j*GROUP+i] = term;
            end
        end
        return {c[SLICE-1], gc[NGRP], x ^ y ^ c};
    endfunction

    // Stage registers.
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic              carry_q [STAGES];
    logic              cout_q, ovf_q, zero_q;

    // Stage inputs: stage 0 takes the ports, stage k takes stage k-1.
    logic [STAGES-1:0] v_src, c_src;
    logic [WIDTH-1:0]  a_src   [STAGES];
    logic [WIDTH-1:0]  b_src   [STAGES];
    logic [WIDTH-1:0]  res_src [STAGES];
    logic [WIDTH-1:0]  res_nxt [STAGES];
    logic [SLICE+1:0]  slice_r [STAGES];
    logic [STAGES-1:0] adv, load;
    logic [WIDTH-1:0]  fin_sum;
    logic              fin_cout, fin_ovf, fin_zero;

`ifdef CLA_ADDSUB_SAT_EN
    logic              sat_q   [STAGES];
    logic [STAGES-1:0] sat_src;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_src
        if (k == 0) begin : g_port
            assign v_src[0]   = in_valid;
            assign a_src[0]   = a;
            assign b_src[0]   = sub ? ~b : b;
            assign c_src[0]   = cin;
            assign res_src[0] = '0;
`ifdef CLA_ADDSUB_SAT_EN
            assign sat_src[0] = sat;
`endif
        end else begin : g_reg
            assign v_src[k]   = valid_q[k-1];
            assign a_src[k]   = a_q[k-1];
            assign b_src[k]   = b_q[k-1];
            assign c_src[k]   = carry_q[k-1];
            assign res_src[k] = res_q[k-1];
`ifdef CLA_ADDSUB_SAT_EN
            assign sat_src[k] = sat_q[k-1];
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            slice_r[k] = slice_add(a_src[k][k*SLICE +: SLICE],
                                   b_src[k][k*SLICE +: SLICE], c_src[k]);
            res_nxt[k] = res_src[k];
            res_nxt[k][k*SLICE +: SLICE] = slice_r[k][SLICE-1:0];
        end
    end

    // Flags are resolved from the last slice as it enters the output register.
    always_comb begin
        fin_sum  = res_nxt[STAGES-1];
        fin_cout = slice_r[STAGES-1][SLICE];
        fin_ovf  = slice_r[STAGES-1][SLICE] ^ slice_r[STAGES-1][SLICE+1];
`ifdef CLA_ADDSUB_SAT_EN
        // On overflow both operands share a sign, which is the true sign.
        if (sat_src[STAGES-1] && fin_ovf) begin
            fin_sum = a_src[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        fin_zero = (fin_sum == '0);
    end

    // Stage k empties this cycle if any later stage has a hole (bubbles
    // collapse) or the consumer takes the result. Written flat to avoid a
    // combinational chain over adv itself.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            logic full;
            full = 1'b1;
            for (int j = k + 1; j < STAGES; j++) full = full & valid_q[j];
            if (k == STAGES - 1) full = valid_q[k];
            adv[k]  = out_ready || !full;
            load[k] = !valid_q[k] || adv[k];
        end
    end

    assign in_ready = load[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                res_q[k]   <= '0;
                carry_q[k] <= 1'b0;
`ifdef CLA_ADDSUB_SAT_EN
                sat_q[k]   <= 1'b0;
`endif
            end
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_q[k] <= v_src[k];
                    if (v_src[k]) begin
                        a_q[k]     <= a_src[k];
                        b_q[k]     <= b_src[k];
                        res_q[k]   <= (k == STAGES - 1) ? fin_sum : res_nxt[k];
                        carry_q[k] <= slice_r[k][SLICE];
`ifdef CLA_ADDSUB_SAT_EN
                        sat_q[k]   <= sat_src[k];
`endif
                    end
                end
            end
            if (load[STAGES-1] && v_src[STAGES-1]) begin
                cout_q <= fin_cout;
                ovf_q  <= fin_ovf;
                zero_q <= fin_zero;
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_addsub_pipe
//
// Scoreboarded bench for cla_addsub_pipe. Expected {cout, ovf, zero, sum} is
// pushed when an operand transfer completes and popped when a result transfer
// completes. Define CLA_ADDSUB_SAT_EN for both files to exercise saturation.
// -----------------------------------------------------------------------------
module tb_cla_addsub_pipe;

    localparam int WIDTH  = 32;
    localparam int GROUP  = 4;
    localparam int STAGES = 2;
    localparam int EW     = WIDTH + 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             sub, cin, sat_drv;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout, ovf, zero;

    logic [EW-1:0] exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            in_cnt  = 0;
    int            out_cnt = 0;
    logic          hold_v  = 1'b0;
    logic [WIDTH-1:0] hold_sum;
    logic          rand_done;
    logic          stall_seen;

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    cla_addsub_pipe #(.WIDTH(WIDTH), .GROUP(GROUP), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
`ifdef CLA_ADDSUB_SAT_EN
        .sat(sat_drv),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- check
    task automatic check_eq(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input logic c, input logic o,
                                           input logic z, input logic [WIDTH-1:0] s);
        return {c, o, z, s};
    endfunction

    // Reference: plain wide addition, overflow from operand/result signs.
    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] av,
                                            input logic [WIDTH-1:0] bv,
                                            input logic sv, input logic cv,
                                            input logic satv);
        logic [WIDTH-1:0] be, s;
        logic [WIDTH:0]   full;
        logic             o;
        be   = sv ? ~bv : bv;
        full = {1'b0, av} + {1'b0, be} + {{WIDTH{1'b0}}, cv};
        s    = full[WIDTH-1:0];
        o    = (av[WIDTH-1] == be[WIDTH-1]) && (s[WIDTH-1] != av[WIDTH-1]);
        if (satv && o) s = av[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        return {full[WIDTH], o, (s == '0), s};
    endfunction

    // ---------------------------------------------------------------- driver
    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic sv, input logic cv, input logic satv,
                        input logic [EW-1:0] expv);
        int   waited;
        logic ok;
        waited   = 0;
        ok       = 1'b0;
        a        = av;
        b        = bv;
        sub      = sv;
        cin      = cv;
        sat_drv  = satv;
        in_valid = 1'b1;
        while (!ok && waited < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        if (ok) begin
            exp_q.push_back(expv);
            in_cnt++;
        end else begin
            check_eq("send_timeout", in_ready, 1);
        end
    endtask

    task automatic send_m(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic sv, input logic cv, input logic satv);
        send(av, bv, sv, cv, satv, model(av, bv, sv, cv, satv));
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(WIDTH-1){1'b1}}};
            3:       return {1'b1, {(WIDTH-1){1'b0}}};
            default: return $urandom;
        endcase
    endfunction

    function automatic logic rand_sat();
`ifdef CLA_ADDSUB_SAT_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain", exp_q.size(), 0);
    endtask

    // ---------------------------------------------------------------- scoreboard
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_sum", sum, hold_sum);
            end
            hold_v = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sum",  sum,  e[WIDTH-1:0]);
                    check_eq("cout", cout, e[WIDTH+2]);
                    check_eq("ovf",  ovf,  e[WIDTH+1]);
                    check_eq("zero", zero, e[WIDTH]);
                    out_cnt++;
                end
            end else if (out_valid) begin
                hold_v   = 1'b1;
                hold_sum = sum;
            end
        end
    end

    // ---------------------------------------------------------------- main
    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        cin       = 1'b0;
        sat_drv   = 1'b0;
        out_ready = 1'b1;
        rand_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_sum", sum, 0);
        check_eq("rst_flags", {cout, ovf, zero}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Full carry ripple through both slices, plus latency.
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, pack(1'b1, 1'b0, 1'b1, 32'h0));
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check_eq("latency", lat, STAGES);
        drain();

        // Subtract with and without borrow, signed overflow.
        send(32'd5, 32'd7, 1'b1, 1'b1, 1'b0, pack(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE));
        send(32'd7, 32'd5, 1'b1, 1'b1, 1'b0, pack(1'b1, 1'b0, 1'b0, 32'h2));
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, pack(1'b0, 1'b1, 1'b0, 32'h8000_0000));
        send(32'h8000_0000, 32'h1, 1'b1, 1'b1, 1'b0, pack(1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF));
`ifdef CLA_ADDSUB_SAT_EN
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, pack(1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF));
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, pack(1'b1, 1'b1, 1'b0, 32'h8000_0000));
`endif
        drain();

        // Backpressure: consumer stalls while five ops are offered back to back.
        stall_seen = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send_m($urandom, $urandom, 1'($urandom_range(0, 1)),
                                                   1'($urandom_range(0, 1)), 1'b0);
            end
            begin
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (!in_ready) stall_seen = 1'b1;
                    @(posedge clk);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        check_eq("bp_in_ready_low", stall_seen, 1);
        drain();

        // Reset with two ops in flight: both must vanish.
        out_ready = 1'b0;
        send_m(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        send_m(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_sum", sum, 0);
        check_eq("mid_rst_flags", {cout, ovf, zero}, 0);
        exp_q.delete();
        in_cnt = out_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", in_ready, 1);
        repeat (5) begin
            @(negedge clk);
            check_eq("no_ghost", out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random consumer readiness.
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end else begin
                        send_m(rand_word(), rand_word(), 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)), rand_sat());
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check_eq("count_in_out", out_cnt, in_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
Parametrised, pipelined adder/subtractor built from 4-bit carry-lookahead groups with a second-level group-lookahead carry per slice. Operands enter through a valid/ready handshake. The carry chain is cut into STAGES register slices, and the result leaves through a valid/ready handshake with carry, signed-overflow and zero flags. It is the datapath adder for the ALU and address-generation paths.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of GROUP*STAGES.
GROUP, 4, bits per carry-lookahead group (generate/propagate unit).
STAGES, 2, pipeline register stages; WIDTH/STAGES bits resolved per stage; range 1..WIDTH/GROUP.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transfer request
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  1 = subtract (A + ~B + cin), 0 = add (A + B + cin)
cin  input  1  carry-in; for subtract, 1 = no borrow
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry out of bit WIDTH-1 (for subtract, 1 = no borrow)
ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB
zero  output  1  sum == 0

Behaviour:
- Reset (rst_n low, async): every stage valid bit = 0; out_valid = 0; sum, cout, ovf, zero = 0; in_ready = 1 once reset is released. All in-flight operations are discarded with no output.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_valid, a, b, sub and cin are sampled only on an input transfer.
- Stage 0 inverts B when sub = 1 and registers the lowest slice result, its carry, the remaining operand slices and sub.
- Stage k (1..STAGES-1) adds slice k using the carry registered from stage k-1. It passes lower result bits forward and delays the upper operands.
- Within each slice:
  - g = a&b and p = a|b per bit; each group uses lookahead carries per the standard generate/propagate equations.
  - Group G/P feeds a slice-level lookahead; no ripple between groups inside a slice.
- Latency: exactly STAGES cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 op/cycle.
- Pipeline control:
  - Stage i advances when its successor is empty or advancing; the last stage advances when out_ready = 1 or out_valid = 0.
  - Bubbles collapse.
  - in_ready = !valid[0] || advance[0]; this is combinational from out_ready through the advance chain.
- Backpressure: with out_ready held low, up to STAGES ops are held with no loss. Order is strictly FIFO; outputs hold stable while out_valid && !out_ready.
- Simultaneous input and output transfer on a full pipeline is allowed: the pipeline stays full with no bubble.
- Flags are computed in the final stage and are registered with sum. ovf uses the effective (possibly inverted) B.
- STAGES = 1: the block is a single registered full-width CLA with the same handshake.

Optional Feature:
Macro CLA_ADDSUB_SAT_EN.
- Defined: adds input port sat (1 bit), sampled with operands and pipelined alongside. When sat = 1 and ovf = 1:
  - sum clamps to 2^(WIDTH-1)-1 if the true result is positive, or 2^(WIDTH-1) if negative.
  - ovf still reports 1; zero reflects the clamped sum.
- Not defined: sat port is absent and results always wrap modulo 2^WIDTH.

Test Plan:
- Reset: assert rst_n low mid-stream with 2 ops in flight -> out_valid = 0 and sum/flags = 0 immediately; after release in_ready = 1 and neither dropped op ever appears.
- Carry propagation (WIDTH=32, STAGES=2): a=0xFFFFFFFF, b=0x00000001, sub=0, cin=0 -> after 2 cycles sum=0x00000000, cout=1, zero=1, ovf=0.
- Subtract: a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0, zero=0. Also a=7, b=5 -> sum=2, cout=1.
- Signed overflow: a=0x7FFFFFFF, b=1, add, cin=0 -> sum=0x80000000, ovf=1. With CLA_ADDSUB_SAT_EN and sat=1 -> sum=0x7FFFFFFF, ovf=1.
- Backpressure: 5 back-to-back ops, out_ready low for cycles 2-5 -> in_ready deasserts once 2 ops are held; all 5 results emerge in order, unchanged while stalled.
- Random: 10k random a/b/sub/cin with random out_ready and in_valid -> every result matches the reference model {cout,sum} = a + (sub?~b:b) + cin; ovf/zero match; count in == count out.
